// File: rtl/player_step_controller_if.sv
// Joypad/raster inputs and scroll/sprite/encounter outputs of the overworld step controller.
// master drives the joypad and raster side; slave is the controller itself.
interface player_step_controller_if;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        start;
    logic        up;
    logic        down;
    logic        left;
    logic        right;
    logic        run;
    logic [10:0] map_x;
    logic [9:0]  map_y;
    logic        moving;
    logic [1:0]  facing;
    logic        battle_trigger;
    logic [5:0]  sprite_sel_x;
    logic [5:0]  sprite_sel_y;

    modport master (
        output hcount, vcount, start, up, down, left, right, run,
        input  map_x, map_y, moving, facing, battle_trigger, sprite_sel_x, sprite_sel_y
    );

    modport slave (
        input  hcount, vcount, start, up, down, left, right, run,
        output map_x, map_y, moving, facing, battle_trigger, sprite_sel_x, sprite_sel_y
    );
endinterface

// File: rtl/player_step_controller.sv
// Tile-locked overworld mover: one tile step per frame-tick FSM, bound clamping, walk animation, grass encounters.
// Define PLAYER_RUN_EN to enable the run button (double-speed steps latched at step start).
module player_step_controller #(
    parameter int TILE        = 16,
    parameter int STEP_FRAMES = 8,
    parameter int START_X     = 432,
    parameter int START_Y     = 312,
    parameter int MAP_X_MIN   = 0,
    parameter int MAP_X_MAX   = 1008,
    parameter int MAP_Y_MIN   = 0,
    parameter int MAP_Y_MAX   = 752,
    parameter int GRASS_X_LO  = 368,
    parameter int GRASS_X_HI  = 416,
    parameter int GRASS_Y_LO  = 248,
    parameter int GRASS_Y_HI  = 280,
    parameter int ENC_THRESH  = 32
) (
    input  logic                     vclk,
    input  logic                     reset_n,
    player_step_controller_if.slave  io
);

    localparam int STEP_PX = TILE / STEP_FRAMES;
    localparam int CW      = $clog2(STEP_FRAMES + 1);

    localparam logic signed [11:0] TILE_S    = 12'(TILE);
    localparam logic signed [11:0] X_MIN_S   = 12'(MAP_X_MIN);
    localparam logic signed [11:0] X_MAX_S   = 12'(MAP_X_MAX);
    localparam logic signed [11:0] Y_MIN_S   = 12'(MAP_Y_MIN);
    localparam logic signed [11:0] Y_MAX_S   = 12'(MAP_Y_MAX);
    localparam logic [10:0]        GX_LO     = 11'(GRASS_X_LO);
    localparam logic [10:0]        GX_HI     = 11'(GRASS_X_HI);
    localparam logic [9:0]         GY_LO     = 10'(GRASS_Y_LO);
    localparam logic [9:0]         GY_HI     = 10'(GRASS_Y_HI);
    localparam logic [8:0]         ENC_T     = 9'(ENC_THRESH);

    if ((TILE % STEP_FRAMES) != 0 || (STEP_FRAMES % 2) != 0) begin : g_cfg_err
        $error("STEP_FRAMES must divide TILE and be even");
    end

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_CHECK} state_t;
    typedef enum logic [1:0] {DIR_DOWN = 2'd0, DIR_UP = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_t;

    state_t                state_q, state_d;
    dir_t                  facing_q, facing_d, dir_q, dir_d, req_dir;
    logic [10:0]           map_x_q, map_x_d;
    logic [9:0]            map_y_q, map_y_d;
    logic [CW-1:0]         step_cnt, cnt_d, step_len, half_len;
    logic                  leg, leg_d, bt_q, bt_d;
    logic [15:0]           lfsr;
    logic                  lfsr_fb, tick, any_dir, in_bounds, in_grass, enc_hit;
    logic signed [11:0]    tgt_x, tgt_y;
    logic [10:0]           step_px;

`ifdef PLAYER_RUN_EN
    logic run_q, run_d;
    assign step_px  = run_q ? 11'(2 * STEP_PX) : 11'(STEP_PX);
    assign step_len = run_q ? CW'(STEP_FRAMES / 2) : CW'(STEP_FRAMES);
`else
    logic unused_run;
    assign unused_run = io.run;
    assign step_px    = 11'(STEP_PX);
    assign step_len   = CW'(STEP_FRAMES);
`endif

    assign half_len = step_len >> 1;
    assign tick     = io.start && (io.hcount == '0) && (io.vcount == '0);
    assign any_dir  = io.up || io.down || io.left || io.right;
    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign in_grass = (map_x_q > GX_LO) && (map_x_q <= GX_HI) && (map_y_q > GY_LO) && (map_y_q <= GY_HI);
    assign enc_hit  = {1'b0, lfsr[7:0]} < ENC_T;

    // Target is formed in 12-bit signed so a step below zero stays negative instead of wrapping.
    always_comb begin
        req_dir = DIR_RIGHT;
        tgt_x   = {1'b0, map_x_q};
        tgt_y   = {2'b00, map_y_q};
        if (io.up) begin
            req_dir = DIR_UP;
            tgt_y   = tgt_y + TILE_S;
        end else if (io.down) begin
            req_dir = DIR_DOWN;
            tgt_y   = tgt_y - TILE_S;
        end else if (io.left) begin
            req_dir = DIR_LEFT;
            tgt_x   = tgt_x + TILE_S;
        end else begin
            tgt_x   = tgt_x - TILE_S;
        end
    end

    assign in_bounds = (tgt_x >= X_MIN_S) && (tgt_x <= X_MAX_S) && (tgt_y >= Y_MIN_S) && (tgt_y <= Y_MAX_S);

    always_comb begin
        state_d  = state_q;
        map_x_d  = map_x_q;
        map_y_d  = map_y_q;
        facing_d = facing_q;
        dir_d    = dir_q;
        cnt_d    = step_cnt;
        leg_d    = leg;
        bt_d     = 1'b0;
`ifdef PLAYER_RUN_EN
        run_d    = run_q;
`endif
        if (io.start) begin
            unique case (state_q)
                S_IDLE: begin
                    if (tick && any_dir) begin
                        facing_d = req_dir;
                        if (in_bounds) begin
                            dir_d   = req_dir;
                            cnt_d   = '0;
                            state_d = S_STEP;
`ifdef PLAYER_RUN_EN
                            run_d   = io.run;
`endif
                        end
                    end
                end
                S_STEP: begin
                    if (tick) begin
                        case (dir_q)
                            DIR_UP:   map_y_d = map_y_q + step_px[9:0];
                            DIR_DOWN: map_y_d = map_y_q - step_px[9:0];
                            DIR_LEFT: map_x_d = map_x_q + step_px;
                            default:  map_x_d = map_x_q - step_px;
                        endcase
                        cnt_d = step_cnt + 1'b1;
                        if (cnt_d == step_len) state_d = S_CHECK;
                    end
                end
                default: begin
                    leg_d   = ~leg;
                    bt_d    = in_grass && enc_hit;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge vclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            map_x_q  <= 11'(START_X);
            map_y_q  <= 10'(START_Y);
            facing_q <= DIR_DOWN;
            dir_q    <= DIR_DOWN;
            step_cnt <= '0;
            leg      <= 1'b0;
            bt_q     <= 1'b0;
            lfsr     <= 16'hACE1;
        end else begin
            state_q  <= state_d;
            map_x_q  <= map_x_d;
            map_y_q  <= map_y_d;
            facing_q <= facing_d;
            dir_q    <= dir_d;
            step_cnt <= cnt_d;
            leg      <= leg_d;
            bt_q     <= bt_d;
            lfsr     <= {lfsr[14:0], lfsr_fb};
        end
    end

`ifdef PLAYER_RUN_EN
    always_ff @(posedge vclk or negedge reset_n) begin
        if (!reset_n) run_q <= 1'b0;
        else          run_q <= run_d;
    end
`endif

    assign io.map_x          = map_x_q;
    assign io.map_y          = map_y_q;
    assign io.moving         = (state_q == S_STEP);
    assign io.facing         = facing_q;
    assign io.sprite_sel_y   = {facing_q, 4'b0000};
    assign io.sprite_sel_x   = (state_q == S_STEP && step_cnt < half_len) ? (leg ? 6'd32 : 6'd16) : 6'd0;
    assign io.battle_trigger = bt_q && io.start;

endmodule

// File: tb/tb_player_step_controller.sv
// Directed bench for player_step_controller: frame ticks driven by hand, a frame-level model
// of the default instance compared every cycle, literal pins on bound and encounter instances.
`timescale 1ns/1ps
module tb_player_step_controller;
    logic        vclk    = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] hc      = 11'd5;
    logic [9:0]  vc      = 10'd5;
    logic        st      = 1'b0;
    bit          cmp_en  = 1'b0;
    int          checks  = 0;
    int          errors  = 0;
    int          hi_cnt  = 0;
    int          lo_cnt  = 0;

    always #5 vclk = ~vclk;

    player_step_controller_if m_if ();
    player_step_controller_if e_if ();
    player_step_controller_if h_if ();
    player_step_controller_if l_if ();

    assign m_if.hcount = hc; assign m_if.vcount = vc; assign m_if.start = st;
    assign e_if.hcount = hc; assign e_if.vcount = vc; assign e_if.start = st;
    assign h_if.hcount = hc; assign h_if.vcount = vc; assign h_if.start = st;
    assign l_if.hcount = hc; assign l_if.vcount = vc; assign l_if.start = st;

    player_step_controller u_main (.vclk(vclk), .reset_n(reset_n), .io(m_if));
    player_step_controller #(.START_X(1008), .START_Y(0)) u_edge (.vclk(vclk), .reset_n(reset_n), .io(e_if));
    player_step_controller #(.START_Y(264), .ENC_THRESH(256)) u_enc_hi (.vclk(vclk), .reset_n(reset_n), .io(h_if));
    player_step_controller #(.START_Y(264), .ENC_THRESH(0)) u_enc_lo (.vclk(vclk), .reset_n(reset_n), .io(l_if));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One frame: a single tick cycle followed by three non-tick cycles.
    task automatic frame();
        @(posedge vclk); #2 hc = 11'd0; vc = 10'd0;
        @(posedge vclk); #2 hc = 11'd1; vc = 10'd1;
        repeat (3) @(posedge vclk);
        #2;
    endtask

    // Frame-level model of u_main (default parameters): integer positions, moves done per step.
    int         mx, my, mface, mleg, mdone, mtotal, mdx, mdy, mbt;
    bit         mbusy, mcheck;
    logic [15:0] mlfsr;

    always @(posedge vclk or negedge reset_n) begin : model
        bit tick;
        int nbt, fdx, fdy, per;
        if (!reset_n) begin
            mx = 432; my = 312; mface = 0; mleg = 0; mdone = 0; mtotal = 8;
            mdx = 0; mdy = 0; mbt = 0; mbusy = 0; mcheck = 0; mlfsr = 16'hACE1;
        end else begin
            tick = m_if.start && m_if.hcount == 0 && m_if.vcount == 0;
            nbt  = 0;
            if (mcheck) begin
                if (m_if.start) begin
                    mcheck = 0;
                    mleg   = 1 - mleg;
                    if (mx > 368 && mx <= 416 && my > 248 && my <= 280 && int'(mlfsr[7:0]) < 32) nbt = 1;
                end
            end else if (mbusy) begin
                if (tick) begin
                    mx += mdx; my += mdy; mdone++;
                    if (mdone == mtotal) begin mbusy = 0; mcheck = 1; end
                end
            end else if (tick && (m_if.up || m_if.down || m_if.left || m_if.right)) begin
                fdx = 0; fdy = 0; per = 2; mtotal = 8;
`ifdef PLAYER_RUN_EN
                if (m_if.run) begin per = 4; mtotal = 4; end
`endif
                if (m_if.up)        begin mface = 1; fdy = 1;  end
                else if (m_if.down) begin mface = 0; fdy = -1; end
                else if (m_if.left) begin mface = 2; fdx = 1;  end
                else                begin mface = 3; fdx = -1; end
                if (mx + 16*fdx >= 0 && mx + 16*fdx <= 1008 && my + 16*fdy >= 0 && my + 16*fdy <= 752) begin
                    mbusy = 1; mdone = 0; mdx = fdx * per; mdy = fdy * per;
                end
            end
            mbt   = nbt;
            mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
        end
    end

    always @(negedge vclk) begin
        if (cmp_en) begin
            chk("mdl_map_x",  int'(m_if.map_x), mx);
            chk("mdl_map_y",  int'(m_if.map_y), my);
            chk("mdl_moving", int'(m_if.moving), int'(mbusy));
            chk("mdl_facing", int'(m_if.facing), mface);
            chk("mdl_spr_y",  int'(m_if.sprite_sel_y), 16 * mface);
            chk("mdl_spr_x",  int'(m_if.sprite_sel_x), (mbusy && mdone * 2 < mtotal) ? (mleg ? 32 : 16) : 0);
            chk("mdl_battle", int'(m_if.battle_trigger), (mbt != 0 && m_if.start) ? 1 : 0);
        end
        if (reset_n) begin
            if (h_if.battle_trigger) hi_cnt++;
            if (l_if.battle_trigger) lo_cnt++;
        end
    end

    initial begin
        m_if.up = 0; m_if.down = 0; m_if.left = 0; m_if.right = 0; m_if.run = 0;
        e_if.up = 0; e_if.down = 0; e_if.left = 0; e_if.right = 0; e_if.run = 0;
        h_if.up = 0; h_if.down = 0; h_if.left = 0; h_if.right = 0; h_if.run = 0;
        l_if.up = 0; l_if.down = 0; l_if.left = 0; l_if.right = 0; l_if.run = 0;

        repeat (3) @(posedge vclk);
        #2;
        chk("rst_map_x", int'(m_if.map_x), 432);
        chk("rst_map_y", int'(m_if.map_y), 312);
        chk("rst_moving", int'(m_if.moving), 0);
        chk("rst_facing", int'(m_if.facing), 0);
        chk("rst_spr_x", int'(m_if.sprite_sel_x), 0);
        chk("rst_spr_y", int'(m_if.sprite_sel_y), 0);
        chk("rst_battle", int'(m_if.battle_trigger), 0);
        reset_n = 1; st = 1; cmp_en = 1;

        // Walk up; edge instance turns against the x bound; encounter instances step right into grass.
        m_if.up = 1; e_if.left = 1; h_if.right = 1; l_if.right = 1;
        frame();
        chk("up_t1_moving", int'(m_if.moving), 1);
        chk("up_t1_spr_y", int'(m_if.sprite_sel_y), 16);
        chk("up_t1_spr_x", int'(m_if.sprite_sel_x), 16);
        chk("up_t1_map_y", int'(m_if.map_y), 312);
        chk("edge_left_facing", int'(e_if.facing), 2);
        chk("edge_left_spr_y", int'(e_if.sprite_sel_y), 32);
        chk("edge_left_map_x", int'(e_if.map_x), 1008);
        chk("edge_left_moving", int'(e_if.moving), 0);
        e_if.left = 0; e_if.down = 1; h_if.right = 0; l_if.right = 0;
        frame();
        chk("up_t2_map_y", int'(m_if.map_y), 314);
        chk("edge_down_facing", int'(e_if.facing), 0);
        chk("edge_down_map_y", int'(e_if.map_y), 0);
        chk("edge_down_moving", int'(e_if.moving), 0);
        e_if.down = 0;
        frame(); frame();
        chk("up_t4_spr_x", int'(m_if.sprite_sel_x), 16);
        chk("up_t4_map_y", int'(m_if.map_y), 318);
        frame();
        chk("up_t5_spr_x", int'(m_if.sprite_sel_x), 0);
        chk("up_t5_map_y", int'(m_if.map_y), 320);
        repeat (4) frame();
        chk("up_t9_map_y", int'(m_if.map_y), 328);
        chk("up_t9_moving", int'(m_if.moving), 0);
        chk("enc_hi_map_x", int'(h_if.map_x), 416);
        chk("enc_lo_map_x", int'(l_if.map_x), 416);
        frame();
        chk("up_t10_moving", int'(m_if.moving), 1);
        chk("up_t10_spr_x_leg", int'(m_if.sprite_sel_x), 32);
        m_if.up = 0;
        repeat (8) frame();
        chk("up_step2_map_y", int'(m_if.map_y), 344);

        // Priority, mid-step joypad change, freeze.
        m_if.up = 1; m_if.left = 1;
        frame();
        chk("prio_facing", int'(m_if.facing), 1);
        chk("prio_moving", int'(m_if.moving), 1);
        m_if.up = 0; m_if.left = 0; m_if.down = 1;
        repeat (4) frame();
        chk("midsw_map_y", int'(m_if.map_y), 352);
        st = 0;
        repeat (100) frame();
        chk("freeze_map_y", int'(m_if.map_y), 352);
        chk("freeze_moving", int'(m_if.moving), 1);
        st = 1;
        repeat (4) frame();
        chk("resume_map_y", int'(m_if.map_y), 360);
        chk("resume_facing", int'(m_if.facing), 1);
        m_if.down = 0;
        frame();
        chk("idle_moving", int'(m_if.moving), 0);

        // Right step with run held.
        m_if.right = 1; m_if.run = 1;
        frame();
        chk("run_t1_map_x", int'(m_if.map_x), 432);
        chk("run_t1_spr_y", int'(m_if.sprite_sel_y), 48);
        m_if.right = 0;
        frame();
`ifdef PLAYER_RUN_EN
        chk("run_t2_map_x", int'(m_if.map_x), 428);
        repeat (3) frame();
`else
        chk("run_t2_map_x", int'(m_if.map_x), 430);
        repeat (3) frame();
        chk("run_t5_map_x", int'(m_if.map_x), 424);
        chk("run_t5_moving", int'(m_if.moving), 1);
        repeat (4) frame();
`endif
        chk("run_end_map_x", int'(m_if.map_x), 416);
        chk("run_end_moving", int'(m_if.moving), 0);
        m_if.run = 0;
        chk("enc_hi_pulses", hi_cnt, 1);
        chk("enc_lo_pulses", lo_cnt, 0);

        // Asynchronous reset in the middle of a step.
        m_if.right = 1;
        frame();
        m_if.right = 0;
        frame();
        chk("pre_rst_map_x", int'(m_if.map_x), 414);
        @(posedge vclk); #3 reset_n = 0;
        #1;
        chk("arst_map_x", int'(m_if.map_x), 432);
        chk("arst_map_y", int'(m_if.map_y), 312);
        chk("arst_moving", int'(m_if.moving), 0);
        chk("arst_facing", int'(m_if.facing), 0);
        chk("arst_spr_x", int'(m_if.sprite_sel_x), 0);
        chk("arst_spr_y", int'(m_if.sprite_sel_y), 0);
        chk("arst_battle", int'(m_if.battle_trigger), 0);
        repeat (2) @(posedge vclk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
